// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD sum display scanner.
package bcd_disp_pkg;

    // Active digit slot of the 3-digit scan: S0 = units, S1 = tens, S2 = hundreds.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } slot_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Segment codes for decimal digits 0..9.
    localparam logic [6:0] SEG_CODES [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Scan order S0 -> S1 -> S2 -> S0; the unused encoding recovers to S0.
    function automatic slot_t next_slot(input slot_t s);
        case (s)
            S0:      next_slot = S1;
            S1:      next_slot = S2;
            default: next_slot = S0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Digits above 9 always show a dash, even when blanking is requested.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Dash for invalid digits wins over blanking; otherwise blank or look up the code.
    always_comb begin
        seg = SEG_BLANK;
        if (digit > 4'd9) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            seg = SEG_CODES[digit];
        end
    end

endmodule

// File: rtl/bcd_sum_display_scan.sv
// Latches the adder's three result digits and scans them onto a 3-digit
// common-anode seven-segment display with optional leading-zero blanking
// and an invalid-digit flag. Outputs are registered, so the display lags
// slot and digit changes by one clock.
module bcd_sum_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] sum2,
    input  logic [3:0] sum1,
    input  logic [3:0] sum0,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       err
);

    // A divider of 1 still needs a one-bit counter that simply stays at zero.
    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_reg;
    slot_t         slot_reg;
    logic [3:0]    d0_reg;
    logic [3:0]    d1_reg;
    logic [3:0]    d2_reg;
    logic          err_reg;
    logic [2:0]    an_reg;
    logic [2:0]    an_next;
    logic [6:0]    seg_reg;
    logic [6:0]    seg_next;
    logic [3:0]    digit_sel;
    logic          blank_sel;
    logic          wrap;

    assign wrap = (cnt_reg == CNT_LAST);

    // Capture the adder digits on load and flag any non-BCD digit at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_reg  <= 4'd0;
            d1_reg  <= 4'd0;
            d2_reg  <= 4'd0;
            err_reg <= 1'b0;
        end else if (load) begin
            d0_reg  <= sum0;
            d1_reg  <= sum1;
            d2_reg  <= sum2;
            err_reg <= (sum2 > 4'd9) | (sum1 > 4'd9) | (sum0 > 4'd9);
        end
    end

    // Refresh divider: the slot advances on the cycle the count wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg  <= '0;
            slot_reg <= S0;
        end else if (wrap) begin
            cnt_reg  <= '0;
            slot_reg <= next_slot(slot_reg);
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    // One active-low anode per slot; bit gi is low only while slot gi is active.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_anode
            assign an_next[gi] = (slot_reg != slot_t'(2'(gi)));
        end
    endgenerate

    // Pick the digit for the active slot and decide whether it is a leading zero.
    always_comb begin
        digit_sel = d0_reg;
        blank_sel = 1'b0;
        case (slot_reg)
            S1: begin
                digit_sel = d1_reg;
                blank_sel = BLANK_LEADING && (d2_reg == 4'd0) && (d1_reg == 4'd0);
            end
            S2: begin
                digit_sel = d2_reg;
                blank_sel = BLANK_LEADING && (d2_reg == 4'd0);
            end
            default: begin
                digit_sel = d0_reg;
                blank_sel = 1'b0;
            end
        endcase
    end

    bcd_to_7seg u_dec (
        .digit (digit_sel),
        .blank (blank_sel),
        .seg   (seg_next)
    );

    // Register the decoded pattern so the display pins are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_reg  <= 3'b111;
            seg_reg <= SEG_BLANK;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_bcd_sum_display_scan.sv
// Self-checking bench: two instances (blanking on/off) with REFRESH_DIV=4,
// compared each cycle against a cycle-count based reference model.
module tb_bcd_sum_display_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] sum2 = 4'd0;
    logic [3:0] sum1 = 4'd0;
    logic [3:0] sum0 = 4'd0;
    logic [2:0] an_b, an_n;
    logic [6:0] seg_b, seg_n;
    logic       err_b, err_n;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: edges since reset release, latched digits, error flag.
    int k = 0;
    int md [3] = '{0, 0, 0};
    bit merr = 1'b0;

    always #5 clk = ~clk;

    bcd_sum_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_b (
        .clk(clk), .reset(reset), .load(load),
        .sum2(sum2), .sum1(sum1), .sum0(sum0),
        .an(an_b), .seg(seg_b), .err(err_b)
    );

    bcd_sum_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_n (
        .clk(clk), .reset(reset), .load(load),
        .sum2(sum2), .sum1(sum1), .sum0(sum0),
        .an(an_n), .seg(seg_n), .err(err_n)
    );

    function automatic int code_of(input int v);
        case (v)
            0: code_of = 'h40;  1: code_of = 'h79;  2: code_of = 'h24;
            3: code_of = 'h30;  4: code_of = 'h19;  5: code_of = 'h12;
            6: code_of = 'h02;  7: code_of = 'h78;  8: code_of = 'h00;
            default: code_of = 'h10;
        endcase
    endfunction

    // Expected segments for a slot: dash if invalid, blank if leading zero, else code.
    function automatic int exp_seg(input int sl, input bit bl);
        int v;
        bit blank;
        v = md[sl];
        blank = bl && ((sl == 2 && md[2] == 0) || (sl == 1 && md[2] == 0 && md[1] == 0));
        if (v > 9)      exp_seg = 'h3F;
        else if (blank) exp_seg = 'h7F;
        else            exp_seg = code_of(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, expv, k);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_an_b", {29'd0, an_b}, 32'h7);
        chk("rst_seg_b", {25'd0, seg_b}, 32'h7F);
        chk("rst_err_b", {31'd0, err_b}, 32'h0);
        chk("rst_an_n", {29'd0, an_n}, 32'h7);
        chk("rst_seg_n", {25'd0, seg_n}, 32'h7F);
        chk("rst_err_n", {31'd0, err_n}, 32'h0);
    endtask

    // One clock: drive inputs, model the edge from pre-edge state, then check.
    task automatic tick(input bit ld, input int s2, input int s1, input int s0);
        int sl;
        int ea, esb, esn;
        load = ld;
        sum2 = s2[3:0];
        sum1 = s1[3:0];
        sum0 = s0[3:0];
        @(posedge clk);
        sl  = (k / 4) % 3;
        ea  = 7 & ~(1 << sl);
        esb = exp_seg(sl, 1'b1);
        esn = exp_seg(sl, 1'b0);
        if (ld) begin
            md[2] = s2; md[1] = s1; md[0] = s0;
            merr = (s2 > 9) || (s1 > 9) || (s0 > 9);
            $display("load %0h %0h %0h at k=%0d slot=%0d err=%0b", s2, s1, s0, k, sl, merr);
        end
        k++;
        #1;
        chk("an_b", {29'd0, an_b}, ea);
        chk("seg_b", {25'd0, seg_b}, esb);
        chk("err_b", {31'd0, err_b}, {31'd0, merr});
        chk("an_n", {29'd0, an_n}, ea);
        chk("seg_n", {25'd0, seg_n}, esn);
        chk("err_n", {31'd0, err_n}, {31'd0, merr});
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < 12 && (k % 12) != phase; i++) tick(1'b0, 0, 0, 0);
    endtask

    initial begin
        // Reset is asserted asynchronously and checked before any clock edge.
        #1 reset = 1'b1;
        #1 chk_reset_state();
        @(posedge clk);
        #1 chk_reset_state();
        reset = 1'b0;

        // First edge after release shows units slot with digit 0.
        tick(1'b0, 0, 0, 0);
        chk("first_an", {29'd0, an_b}, 32'h6);
        chk("first_seg", {25'd0, seg_b}, 32'h40);
        idle(11);

        // Normal three-digit value.
        tick(1'b1, 1, 2, 3);
        idle(12);

        // Leading-zero blanking cases.
        tick(1'b1, 0, 0, 7);
        idle(12);
        tick(1'b1, 0, 5, 0);
        idle(12);

        // Invalid tens digit, then cleared by a valid load.
        tick(1'b1, 0, 11, 0);
        chk("err_at_load", {31'd0, err_b}, 32'h1);
        idle(12);
        tick(1'b1, 0, 9, 9);
        chk("err_cleared", {31'd0, err_b}, 32'h0);
        idle(12);

        // Asynchronous reset at count 2 of S1, between clock edges.
        idle_until(6);
        #2 reset = 1'b1;
        #1 chk_reset_state();
        @(posedge clk);
        #1 chk_reset_state();
        reset = 1'b0;
        k = 0; md[0] = 0; md[1] = 0; md[2] = 0; merr = 1'b0;
        tick(1'b1, 1, 4, 6);
        idle(11);

        // Load coinciding with the S2 -> S0 wrap.
        idle_until(11);
        tick(1'b1, 0, 0, 8);
        tick(1'b0, 0, 0, 0);
        chk("coinc_an", {29'd0, an_b}, 32'h6);
        chk("coinc_seg", {25'd0, seg_b}, 32'h00);

        // Randomized loads; hundreds digit biased towards legal adder values.
        for (int i = 0; i < 200; i++) begin
            int r2, r1, r0;
            bit ld;
            ld = ($urandom_range(0, 3) == 0);
            r2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
            r1 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            r0 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            tick(ld, r2, r1, r0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
